// File: rtl/uart_fast_write.sv
// uart_fast_write: oversampled UART transmitter
// 8 data bits MSB first, even parity, one stop bit, fed by a FIFO

module uart_fast_write #(
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] word,
  input  logic       write,
  output logic       uart_stream,
  output logic       full,
  output logic       busy,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          drop_q;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic          line_q;
  logic          line_d;

  logic          empty;
  logic          tick_last;
  logic          pop;
  logic          push;
  logic [7:0]    head;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CFULL);
  assign busy      = (state_q != IDLE) || !empty;
  assign drop      = drop_q;
  assign head      = mem_q[rd_q];
  assign tick_last = (tick_q == TLAST);

  // Pop from IDLE, or on the last stop cycle so frames run back-to-back
  assign pop  = !empty &&
                ((state_q == IDLE) ||
                 ((state_q == STOP) && tick_last));
  // A pop in the same cycle frees the slot a full FIFO needs
  assign push = write && (!full || pop);

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  // FIFO storage; contents need no reset since pointers are flushed
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_q] <= word;
    end
  end

  // FIFO pointers, occupancy and the registered drop pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      drop_q <= write && !push;
    end
  end

  // Line level for the bit the FSM is currently holding
  always_comb begin
    line_d = 1'b1;
    unique case (state_q)
      IDLE:    line_d = 1'b1;
      START:   line_d = 1'b0;
      DATA:    line_d = shift_q[7];
      PARITY:  line_d = parity_q;
      STOP:    line_d = 1'b1;
      default: line_d = 1'b1;
    endcase
  end

  // Frame sequencer with registered serial output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      line_q    <= 1'b1;
    end else begin
      line_q <= line_d;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q  <= head;
            parity_q <= ^head;
            tick_q   <= '0;
            state_q  <= START;
          end
        end
        START: begin
          if (tick_last) begin
            tick_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_last) begin
            tick_q  <= '0;
            shift_q <= {shift_q[6:0], 1'b0};
            if (bit_idx_q == 3'd7) begin
              state_q <= PARITY;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        PARITY: begin
          if (tick_last) begin
            tick_q  <= '0;
            state_q <= STOP;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_last) begin
            tick_q <= '0;
            if (pop) begin
              shift_q  <= head;
              parity_q <= ^head;
              state_q  <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign uart_stream = line_q;

endmodule

// File: tb/tb_uart_fast_write.sv
// tb_uart_fast_write: directed + random checks of the UART transmitter
// against a frame-schedule model and a behavioural receiver

module tb_uart_fast_write;

  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int FL    = 11 * OS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] word = 8'h00;
  logic       write = 1'b0;
  logic       uart_stream;
  logic       full;
  logic       busy;
  logic       drop;

  always #5 clk = ~clk;

  uart_fast_write #(
    .OVERSAMPLE(OS),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .word(word),
    .write(write),
    .uart_stream(uart_stream),
    .full(full),
    .busy(busy),
    .drop(drop)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int drops_seen = 0;

  // Model: per accepted byte, its write edge, pop edge and value
  int         mw[$];
  int         mp[$];
  logic [7:0] mb[$];
  logic       exp_drop = 1'b0;

  // Behavioural receiver output
  logic [7:0] rxq[$];
  int         rx_err = 0;
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_sh = '0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[8-k];
    if (k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic exp_line(input int e);
    for (int i = 0; i < mp.size(); i++) begin
      int o;
      o = e - mp[i] - 1;
      if (o >= 0 && o < FL) return frame_bit(mb[i], o / OS);
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int e);
    for (int i = 0; i < mp.size(); i++)
      if (mw[i] <= e && e < mp[i] + FL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_count(input int e);
    int n;
    n = 0;
    for (int i = 0; i < mp.size(); i++)
      if (mw[i] <= e && mp[i] > e) n++;
    return n;
  endfunction

  // Queue occupancy rule: accept unless DEPTH bytes still wait past this edge
  task automatic model_write(input logic [7:0] b);
    int n;
    int p;
    n = 0;
    for (int i = 0; i < mp.size(); i++)
      if (mp[i] > cyc) n++;
    if (n < DEPTH) begin
      p = cyc + 1;
      if (mp.size() > 0 && mp[mp.size()-1] + FL > p)
        p = mp[mp.size()-1] + FL;
      mw.push_back(cyc);
      mp.push_back(p);
      mb.push_back(b);
    end else begin
      exp_drop = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs
  task automatic step(input logic wr, input logic [7:0] b, input logic rst);
    write = wr;
    word  = b;
    rst_n = !rst;
    @(posedge clk);
    cyc++;
    exp_drop = 1'b0;
    if (rst) begin
      mw.delete();
      mp.delete();
      mb.delete();
    end else if (wr) begin
      model_write(b);
    end
    #1;
    if (drop === 1'b1) drops_seen++;
    check("line", uart_stream, exp_line(cyc));
    check("busy", busy, exp_busy(cyc));
    check("full", full, exp_count(cyc) == DEPTH);
    check("drop", drop, exp_drop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 1'b1);
    write = 1'b0;
  endtask

  // Mid-bit sampling receiver, 8E1 MSB first
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act <= 1'b0;
      rx_cnt <= 0;
    end else if (!rx_act) begin
      if (uart_stream == 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % OS == OS / 2) rx_sh <= {rx_sh[8:0], uart_stream};
      if (rx_cnt == 10 * OS + OS / 2) begin
        rx_act <= 1'b0;
        rxq.push_back(rx_sh[8:1]);
        if (rx_sh[9] !== 1'b0 || uart_stream !== 1'b1 ||
            rx_sh[0] !== ^rx_sh[8:1])
          rx_err <= rx_err + 1;
      end
    end
  end

  initial begin
    logic [7:0] sent[$];
    int w;
    int target;
    int guard;
    logic [7:0] b;

    // Reset state, then a single A5 frame
    do_reset();
    check("rst_line", uart_stream, 1'b1);
    check("rst_busy", busy, 1'b0);
    idle(3);
    step(1'b1, 8'hA5, 1'b0);
    w = cyc;
    guard = 0;
    while (busy === 1'b1 || cyc == w) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
      if (guard > 400) break;
    end
    check_int("busy_fall", cyc - w, 177);
    idle(10);

    // Odd weight byte gives parity 1
    rxq.delete();
    step(1'b1, 8'h07, 1'b0);
    idle(200);
    check_int("par_frames", rxq.size(), 1);
    if (rxq.size() > 0) check_int("par_byte", rxq[0], 8'h07);

    // Burst of six into a 4-deep FIFO
    do_reset();
    rxq.delete();
    drops_seen = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 5) check("burst_full", full, 1'b1);
    end
    idle(5 * FL + 40);
    check_int("burst_drops", drops_seen, 1);
    check_int("burst_frames", rxq.size(), 5);
    for (int i = 0; i < rxq.size(); i++)
      check_int("burst_byte", rxq[i], i + 1);

    // Write on the exact STOP-to-START pop with the FIFO full
    do_reset();
    drops_seen = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    check("coll_pre_full", full, 1'b1);
    target = mp[1];
    guard = 0;
    while (cyc < target - 1 && guard < 1000) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    step(1'b1, 8'h5A, 1'b0);
    check("coll_full", full, 1'b1);
    check("coll_nodrop", drop, 1'b0);
    check_int("coll_cnt", exp_count(cyc), DEPTH);
    idle(6 * FL + 40);
    check_int("coll_drops", drops_seen, 0);

    // Reset during data bit 3 of an FF frame
    do_reset();
    step(1'b1, 8'hFF, 1'b0);
    w = cyc;
    idle(1 + 1 + 4 * OS + 8 - 1);
    step(1'b0, 8'h00, 1'b1);
    check("midrst_line", uart_stream, 1'b1);
    check("midrst_busy", busy, 1'b0);
    rxq.delete();
    idle(400);
    check_int("midrst_frames", rxq.size(), 0);

    // Random loopback through the behavioural receiver
    do_reset();
    rxq.delete();
    sent.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      step(1'b1, b, 1'b0);
      idle($urandom_range(170, 260));
    end
    idle(2 * FL);
    check_int("lb_frames", rxq.size(), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++)
      check_int("lb_byte", rxq[i], sent[i]);
    check_int("lb_perr", rx_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fast_write.md
# uart_fast_write

Oversampled UART transmitter: the serialising counterpart to the 16x-oversampled byte receiver on the same link. It accepts bytes through a single-cycle `write` strobe into a small FIFO and drives a registered serial line. Each frame is start bit, 8 data bits MSB-first, one even-parity bit and one stop bit, with every bit held for `OVERSAMPLE` clock cycles. It sits at the transmit end of the BPSK/UART data path, fed by the same byte-wide `word`/`write` convention the receiver produces.

## Interface

Parameters:
- `OVERSAMPLE`, default 16: clock cycles per serial bit. `clk` runs at `OVERSAMPLE` × baud. Must be at least 2.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  single clock, rising-edge; clock-domain rate is 16× baud at the default `OVERSAMPLE`.
- `rst_n`  in  1  reset, synchronous, active-low.
- `word`  in  8  byte to transmit; sampled when `write` is high.
- `write`  in  1  single-cycle enqueue strobe.
- `uart_stream`  out  1  serial line, registered; idles high.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `busy`  out  1  high while a frame is in flight or the FIFO is non-empty.
- `drop`  out  1  one-cycle pulse when a `write` is rejected.

## Operation

- **FIFO**
  - Circular buffer with `DEPTH` entries, a read pointer, a write pointer and a count of width clog2(`DEPTH`)+1.
  - Pointers wrap modulo `DEPTH`.
  - A write is accepted when `!full`, or when a pop occurs in the same cycle.
  - Otherwise the byte is discarded and `drop` pulses on the next cycle. FIFO contents are unchanged.
  - Push and pop in the same cycle leave the count unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `uart_stream`=1. If the FIFO is non-empty, pop the head into `shift_reg`, compute `parity_bit` = XOR of the 8 bits, clear `tick`, and go to START.
  - **START:** `uart_stream`=0 for `OVERSAMPLE` cycles, then go to DATA with `bit_idx`=0.
  - **DATA:** `uart_stream`=`shift_reg[7]`. After `OVERSAMPLE` cycles, shift left by 1. If `bit_idx`=7, go to PARITY; otherwise increment `bit_idx`.
  - **PARITY:** `uart_stream`=`parity_bit` for `OVERSAMPLE` cycles. The bit is even parity and matches the receiver's check `uart_stream == ^data`.
  - **STOP:** `uart_stream`=1 for `OVERSAMPLE` cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- **Counter rules:**
  - `tick` counts 0..`OVERSAMPLE`-1 and wraps to 0 at each bit boundary.
  - `bit_idx` is 3 bits and counts 0..7.
- **Status outputs:**
  - `busy` = (state != IDLE) || (count != 0).
  - `full` = (count == `DEPTH`).
  - Both are derived from registered state.
- **Reset** (`rst_n` low at a rising edge):
  - `uart_stream`=1, `full`=0, `busy`=0, `drop`=0.
  - FIFO is flushed (pointers and count = 0) and the state is IDLE.
  - A frame in progress is abandoned and the line is high on the cycle after the reset edge.
  - `write` is ignored while `rst_n` is low.

## Timing

- **Latency.** `write` sampled at edge N into an empty FIFO while IDLE: the FIFO is written at N and the FSM pops at N+1. `uart_stream` falls at edge N+2, i.e. it is low starting in the second cycle after the write edge.
- **Frame length.** 11 × `OVERSAMPLE` cycles, which is 176 at the default.
- **Back-to-back frames.** The next start bit begins on the edge after the final stop-bit cycle. That high-to-low transition is the receiver's start edge.
- **Throughput.** One byte per 11 × `OVERSAMPLE` cycles. The FIFO absorbs bursts of up to `DEPTH`+1 bytes without drops: `DEPTH` bytes queued plus one in the shifter.
- **`full`.** Asserts the cycle after the write that fills the last entry. It deasserts the cycle after the pop.
- **`drop`.** Registered, so it is high exactly one cycle, the cycle after the rejected `write`.
- **`busy`.** Falls the cycle after STOP ends with an empty FIFO.

## Test plan

- **Single frame.** Reset, then `write` 8'hA5 once. Required: `uart_stream` low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, parity 0, stop 1 for 16 cycles. The frame starts 2 cycles after the write. `busy` falls 177 cycles after the write.
- **Parity odd weight.** `write` 8'h07. Required: parity bit = 1.
- **Burst and drop.** With `DEPTH`=4, write 8'h01..8'h06 on consecutive cycles.
  - Bytes 01..05 are accepted, since byte 01 is popped before the 5th write.
  - `full` is high after 8'h05.
  - Byte 06 pulses `drop` for 1 cycle.
  - Exactly 5 frames are emitted back-to-back with zero idle cycles between the stop and the next start.
- **Push/pop collision.** Fill the FIFO (`full`=1), then assert `write` on the exact cycle of the STOP-to-START pop. Required: the byte is accepted, there is no `drop`, `full` stays 1 and the count stays 4.
- **Reset mid-frame.** Write 8'hFF, and drop `rst_n` for 1 cycle during DATA bit 3. Required: `uart_stream`=1 the next cycle, `busy`=0, and no further frame is emitted without a new `write`.
- **Loopback.** Connect `uart_stream` to the 16x receiver and send 16 random bytes, spaced so the FIFO never fills. Required: every received `word` equals the byte sent, one receiver `write` pulse per byte, and no parity rejections.
